// File: rtl/exu_alu_arb_if.sv
// Handshake bundle for the shared-ALU arbiter: two requesters, ALU port, response.
`ifndef ALU_OPC_SIZE
`define ALU_OPC_SIZE 4
`endif

interface exu_alu_arb_if #(
  parameter int XLEN  = 32,
  parameter int OPC_W = `ALU_OPC_SIZE,
  parameter int TAG_W = 5
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][OPC_W-1:0] req_opcode;
  logic [1:0][XLEN-1:0]  req_src1;
  logic [1:0][XLEN-1:0]  req_src2;
  logic [1:0][TAG_W-1:0] req_tag;
  logic [OPC_W-1:0]      alu_opcode;
  logic [XLEN-1:0]       alu_src1;
  logic [XLEN-1:0]       alu_src2;
  logic [XLEN-1:0]       alu_dst;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [XLEN-1:0]       rsp_dst;
  logic                  rsp_id;
  logic [TAG_W-1:0]      rsp_tag;

  modport slave (
    input  req_valid, req_opcode, req_src1, req_src2, req_tag,
    output req_ready,
    output alu_opcode, alu_src1, alu_src2,
    input  alu_dst,
    output rsp_valid, rsp_dst, rsp_id, rsp_tag,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_opcode, req_src1, req_src2, req_tag,
    input  req_ready,
    input  alu_opcode, alu_src1, alu_src2,
    output alu_dst,
    input  rsp_valid, rsp_dst, rsp_id, rsp_tag,
    output rsp_ready
  );
endinterface

// File: rtl/exu_alu_arb.sv
// Two-requester arbiter for the shared ALU with a one-entry response slot.
// EXU_ALU_ARB_FIXED_PRIO_EN: requester 0 always wins instead of round-robin.
`ifndef ALU_OPC_SIZE
`define ALU_OPC_SIZE 4
`endif

module exu_alu_arb #(
  parameter int XLEN  = 32,
  parameter int OPC_W = `ALU_OPC_SIZE,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  exu_alu_arb_if.slave  bus
);

  logic             slot_free;
  logic [1:0]       gnt;
  logic             sel;

  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_dst_q,   rsp_dst_d;
  logic             rsp_id_q,    rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;

`ifndef EXU_ALU_ARB_FIXED_PRIO_EN
  logic last_gnt_q, last_gnt_d;
`endif

  // Ready depends only on valids and slot state, never on payload.
  always_comb begin
    slot_free = !rsp_valid_q || bus.rsp_ready;
    gnt       = 2'b00;
    if (slot_free) begin
      unique case (bus.req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
`ifdef EXU_ALU_ARB_FIXED_PRIO_EN
        2'b11:   gnt = 2'b01;
`else
        2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
`endif
        default: gnt = 2'b00;
      endcase
    end
  end

  assign sel           = gnt[1];
  assign bus.req_ready = gnt;

  assign bus.alu_opcode = bus.req_opcode[sel];
  assign bus.alu_src1   = bus.req_src1[sel];
  assign bus.alu_src2   = bus.req_src2[sel];

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_dst_d   = rsp_dst_q;
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    if (|gnt) begin
      rsp_valid_d = 1'b1;
      rsp_dst_d   = bus.alu_dst;
      rsp_id_d    = sel;
      rsp_tag_d   = bus.req_tag[sel];
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_dst_q   <= '0;
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_dst_q   <= rsp_dst_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

`ifndef EXU_ALU_ARB_FIXED_PRIO_EN
  assign last_gnt_d = (|gnt) ? sel : last_gnt_q;

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_gnt_q <= 1'b1;
    else     last_gnt_q <= last_gnt_d;
  end
`endif

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dst   = rsp_dst_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_tag   = rsp_tag_q;

endmodule
